// File: rtl/vai_pkg.sv
// Shared types for the VAI Tx path: a reduced CCI-P Tx view and the
// entry layouts stored in the per-channel Tx elastic buffers.
package vai_pkg;

    localparam int VAI_TXBUF_DEPTH_LOG2_DEF = 5;
    localparam int VAI_TXBUF_SLACK_DEF      = 8;

    typedef struct packed {
        logic [1:0]  vcSel;
        logic [1:0]  clLen;
        logic [3:0]  reqType;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vcSel;
        logic        sop;
        logic [1:0]  clLen;
        logic [3:0]  reqType;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef t_ccip_c0_ReqMemHdr t_vai_c0_entry;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
    } t_vai_c1_entry;

endpackage

// File: rtl/vai_tx_chan_fifo.sv
// One Tx channel FIFO: simple dual-port RAM whose registered read port
// doubles as the channel output register.
module vai_tx_chan_fifo #(
    parameter int WIDTH          = 8,
    parameter int DEPTH_LOG2     = 5,
    parameter int ALM_FULL_SLACK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  popReq,
    output logic                  popValid,
    output logic [WIDTH-1:0]      popData,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  almFull,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ALM_CNT  =
        (DEPTH_LOG2+1)'(DEPTH - ALM_FULL_SLACK);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countNext;
    logic                  full;
    logic                  doPush;
    logic                  doPop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign doPop  = popReq && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot
    assign doPush = push && (!full || doPop);

    always_comb begin
        countNext = count;
        if (doPush && !doPop)
            countNext = count + 1'b1;
        else if (doPop && !doPush)
            countNext = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr] <= pushData;
        if (doPop)
            popData <= mem[rdPtr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            popValid <= 1'b0;
            almFull  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + 1'b1;
            if (doPop)
                rdPtr <= rdPtr + 1'b1;
            count    <= countNext;
            popValid <= doPop;
            almFull  <= (countNext >= ALM_CNT);
            if (push && !doPush)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/vai_tx_buffer.sv
// Per-sub-AFU CCI-P Tx elastic buffer: c0/c1 FIFOs with upstream
// back-pressure, registered c2 pass-through and AFU almost-full.
module vai_tx_buffer
    import vai_pkg::*;
#(
    parameter int DEPTH_LOG2     = VAI_TXBUF_DEPTH_LOG2_DEF,
    parameter int ALM_FULL_SLACK = VAI_TXBUF_SLACK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  t_if_ccip_Tx         afu_TxPort,
    output logic                afu_c0TxAlmFull,
    output logic                afu_c1TxAlmFull,
    output t_if_ccip_Tx         up_TxPort,
    input  logic                up_c0TxAlmFull,
    input  logic                up_c1TxAlmFull,
    output logic [DEPTH_LOG2:0] c0_count,
    output logic [DEPTH_LOG2:0] c1_count,
    output logic                overflow
);

    t_vai_c0_entry  c0Pop;
    t_vai_c1_entry  c1Pop;
    t_vai_c1_entry  c1Push;
    t_if_ccip_c2_Tx c2Q;
    logic c0Valid, c1Valid;
    logic c0Empty, c1Empty;
    logic c0AlmFull, c1AlmFull;
    logic c0Ovf, c1Ovf;
    logic c0UpAlmFullQ, c1UpAlmFullQ;

    assign c1Push.hdr  = afu_TxPort.c1.hdr;
    assign c1Push.data = afu_TxPort.c1.data;

    vai_tx_chan_fifo #(
        .WIDTH          ($bits(t_vai_c0_entry)),
        .DEPTH_LOG2     (DEPTH_LOG2),
        .ALM_FULL_SLACK (ALM_FULL_SLACK)
    ) c0Fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (afu_TxPort.c0.valid),
        .pushData (afu_TxPort.c0.hdr),
        .popReq   (!c0Empty && !c0UpAlmFullQ),
        .popValid (c0Valid),
        .popData  (c0Pop),
        .count    (c0_count),
        .empty    (c0Empty),
        .almFull  (c0AlmFull),
        .overflow (c0Ovf)
    );

    vai_tx_chan_fifo #(
        .WIDTH          ($bits(t_vai_c1_entry)),
        .DEPTH_LOG2     (DEPTH_LOG2),
        .ALM_FULL_SLACK (ALM_FULL_SLACK)
    ) c1Fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (afu_TxPort.c1.valid),
        .pushData (c1Push),
        .popReq   (!c1Empty && !c1UpAlmFullQ),
        .popValid (c1Valid),
        .popData  (c1Pop),
        .count    (c1_count),
        .empty    (c1Empty),
        .almFull  (c1AlmFull),
        .overflow (c1Ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            c0UpAlmFullQ    <= 1'b0;
            c1UpAlmFullQ    <= 1'b0;
            afu_c0TxAlmFull <= 1'b0;
            afu_c1TxAlmFull <= 1'b0;
            c2Q             <= '0;
        end else begin
            c0UpAlmFullQ    <= up_c0TxAlmFull;
            c1UpAlmFullQ    <= up_c1TxAlmFull;
            afu_c0TxAlmFull <= c0AlmFull;
            afu_c1TxAlmFull <= c1AlmFull;
            c2Q             <= afu_TxPort.c2;
        end
    end

    assign overflow = c0Ovf | c1Ovf;

    always_comb begin
        up_TxPort          = '0;
        up_TxPort.c0.hdr   = c0Pop;
        up_TxPort.c0.valid = c0Valid;
        up_TxPort.c1.hdr   = c1Pop.hdr;
        up_TxPort.c1.data  = c1Pop.data;
        up_TxPort.c1.valid = c1Valid;
        up_TxPort.c2       = c2Q;
    end

endmodule

// File: tb/tb_vai_tx_buffer.sv
// Directed bench for vai_tx_buffer: latency, ordering, back-pressure,
// overflow, c2 pass-through and reset while draining.
module tb_vai_tx_buffer;
    import vai_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    t_if_ccip_Tx afuTx;
    t_if_ccip_Tx upTx;
    logic        afuC0AlmFull, afuC1AlmFull;
    logic        upC0AlmFull, upC1AlmFull;
    logic [5:0]  c0Count, c1Count;
    logic        overflow;
    int          checks = 0;
    int          errors = 0;

    vai_tx_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .afu_TxPort      (afuTx),
        .afu_c0TxAlmFull (afuC0AlmFull),
        .afu_c1TxAlmFull (afuC1AlmFull),
        .up_TxPort       (upTx),
        .up_c0TxAlmFull  (upC0AlmFull),
        .up_c1TxAlmFull  (upC1AlmFull),
        .c0_count        (c0Count),
        .c1_count        (c1Count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        afuTx = '0;
        upC0AlmFull = 1'b0;
        upC1AlmFull = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_c0v", upTx.c0.valid, 1'b0);
        check("rst_c1v", upTx.c1.valid, 1'b0);
        check("rst_c2v", upTx.c2.mmioRdValid, 1'b0);
        check("rst_alm", {afuC0AlmFull, afuC1AlmFull}, 2'b00);
        check("rst_cnt", {c0Count, c1Count}, 12'd0);
        check("rst_ovf", overflow, 1'b0);

        // single c0 read
        afuTx.c0.valid = 1'b1;
        afuTx.c0.hdr = '0;
        afuTx.c0.hdr.mdata = 16'h00A5;
        afuTx.c0.hdr.address = 42'h123_4567;
        afuTx.c0.hdr.reqType = 4'h1;
        tick();
        afuTx.c0.valid = 1'b0;
        check("c0_t1_valid", upTx.c0.valid, 1'b0);
        check("c0_t1_cnt", c0Count, 6'd1);
        tick();
        check("c0_t2_valid", upTx.c0.valid, 1'b1);
        check("c0_t2_mdata", upTx.c0.hdr.mdata, 16'h00A5);
        check("c0_t2_addr", upTx.c0.hdr.address, 42'h123_4567);
        check("c0_t2_type", upTx.c0.hdr.reqType, 4'h1);
        check("c0_t2_cnt", c0Count, 6'd0);
        tick();
        check("c0_t3_valid", upTx.c0.valid, 1'b0);

        // c1 burst of 20, no back-pressure
        for (int k = 0; k <= 20; k++) begin
            afuTx.c1.valid = (k < 20);
            afuTx.c1.data = 512'(k);
            afuTx.c1.hdr.mdata = 16'(k);
            tick();
            if (k >= 1)
                check("c1_burst", {upTx.c1.valid, upTx.c1.data[31:0]},
                      {1'b1, 32'(k - 1)});
        end
        afuTx.c1.valid = 1'b0;
        tick();
        check("c1_burst_end", upTx.c1.valid, 1'b0);

        // back-pressure on c1, 24 writes
        upC1AlmFull = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            afuTx.c1.valid = 1'b1;
            afuTx.c1.data = 512'(100 + i);
            tick();
        end
        afuTx.c1.valid = 1'b0;
        check("bp_cnt24", c1Count, 6'd24);
        check("bp_alm_same", afuC1AlmFull, 1'b0);
        check("bp_hold_v", upTx.c1.valid, 1'b0);
        tick();
        check("bp_alm_next", afuC1AlmFull, 1'b1);
        check("bp_c0_alm", afuC0AlmFull, 1'b0);
        upC1AlmFull = 1'b0;
        tick();
        check("bp_rel_v", upTx.c1.valid, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick();
            check("bp_drain", {upTx.c1.valid, upTx.c1.data[31:0]},
                  {1'b1, 32'(100 + i)});
        end
        tick();
        check("bp_end_v", upTx.c1.valid, 1'b0);
        check("bp_end_cnt", c1Count, 6'd0);
        check("bp_end_alm", afuC1AlmFull, 1'b0);
        check("bp_ovf", overflow, 1'b0);

        // overflow on c0 (33 reads), fill c1 (32 writes)
        upC0AlmFull = 1'b1;
        upC1AlmFull = 1'b1;
        tick();
        for (int i = 0; i < 33; i++) begin
            afuTx.c0.valid = 1'b1;
            afuTx.c0.hdr.mdata = 16'(i);
            afuTx.c1.valid = (i < 32);
            afuTx.c1.data = 512'(1000 + i);
            tick();
        end
        afuTx.c0.valid = 1'b0;
        afuTx.c1.valid = 1'b0;
        tick();
        check("ovf_c0cnt", c0Count, 6'd32);
        check("ovf_c1cnt", c1Count, 6'd32);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_alm", {afuC0AlmFull, afuC1AlmFull}, 2'b11);
        check("ovf_hold_v", {upTx.c0.valid, upTx.c1.valid}, 2'b00);

        // c2 pass-through while both FIFOs are full
        afuTx.c2.mmioRdValid = 1'b1;
        afuTx.c2.hdr.tid = 9'h01F;
        afuTx.c2.data = 64'hDEAD_BEEF_0123_4567;
        tick();
        afuTx.c2.mmioRdValid = 1'b0;
        check("c2_valid", upTx.c2.mmioRdValid, 1'b1);
        check("c2_tid", upTx.c2.hdr.tid, 9'h01F);
        check("c2_data", upTx.c2.data, 64'hDEAD_BEEF_0123_4567);
        tick();
        check("c2_off", upTx.c2.mmioRdValid, 1'b0);

        upC0AlmFull = 1'b0;
        upC1AlmFull = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            check("ovf_c0_drain", {upTx.c0.valid, upTx.c0.hdr.mdata},
                  {1'b1, 16'(i)});
            check("ovf_c1_drain", {upTx.c1.valid, upTx.c1.data[31:0]},
                  {1'b1, 32'(1000 + i)});
        end
        tick();
        check("ovf_no33", upTx.c0.valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_cnt0", {c0Count, c1Count}, 12'd0);

        // reset while draining
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("rst2_ovf", overflow, 1'b0);
        upC0AlmFull = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            afuTx.c0.valid = 1'b1;
            afuTx.c0.hdr.mdata = 16'(200 + i);
            tick();
        end
        afuTx.c0.valid = 1'b0;
        upC0AlmFull = 1'b0;
        tick();
        tick();
        check("mid_first", {upTx.c0.valid, upTx.c0.hdr.mdata},
              {1'b1, 16'd200});
        check("mid_cnt", c0Count, 6'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_v", {upTx.c0.valid, upTx.c1.valid,
                            upTx.c2.mmioRdValid}, 3'b000);
        check("mid_rst_cnt", {c0Count, c1Count}, 12'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_after", {upTx.c0.valid, c0Count}, 7'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
